// File: rtl/reel_speed_sequencer.sv
// ----------------------------------------------------------------------------
// reel_speed_sequencer
//   Sequences the per-reel clock dividers of the slot machine. On start it
//   re-phases every divider with a one-cycle reset pulse, ramps all reels from
//   MIN_SPEED to MAX_SPEED, holds them at full spin, then decelerates the reels
//   one by one with a fixed tick stagger between successive reels.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   start    in   start a spin (honoured only in IDLE)
//   stop     in   stop request (latched in RAMP_UP, acted on in SPIN)
//   speed    out  reel k speed at [20k+19:20k], feeds clock_divider speed
//   div_rst  out  per-reel divider reset (divider acts on its falling edge)
//   reel_run out  1 = reel k spinning
//   busy     out  1 in RAMP_UP / SPIN / RAMP_DOWN
//   done     out  one-cycle pulse once every reel has stopped
//   state    out  IDLE=0 RAMP_UP=1 SPIN=2 RAMP_DOWN=3 DONE=4
//
// Build option
//   AUTO_STOP_EN : when defined, SPIN leaves by itself after AUTO_STOP_TICKS
//                  ticks; otherwise SPIN exits only through stop.
//
// Every output is a flop: the combinational block computes next values for
// all state and outputs, the sequential block registers them.
// ----------------------------------------------------------------------------
module reel_speed_sequencer #(
  parameter int unsigned NUM_REELS       = 3,
  parameter logic [19:0] MIN_SPEED       = 20'd2,
  parameter logic [19:0] MAX_SPEED       = 20'd50,
  parameter logic [19:0] SPEED_STEP      = 20'd4,
  parameter int unsigned TICK_CYCLES     = 5000000,
  parameter int unsigned STAGGER_TICKS   = 5,
  parameter int unsigned AUTO_STOP_TICKS = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  output logic [20*NUM_REELS-1:0]   speed,
  output logic [NUM_REELS-1:0]      div_rst,
  output logic [NUM_REELS-1:0]      reel_run,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_SPIN      = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [31:0]           tick_idx_q, tick_idx_d;
  logic [19:0]           spd_q [NUM_REELS];
  logic [19:0]           spd_d [NUM_REELS];
  logic [NUM_REELS-1:0]  run_q, run_d;
  logic [NUM_REELS-1:0]  drst_q, drst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;
  logic                  tick;
  logic                  all_max;
  logic                  spin_exit;
  logic [20:0]           sum_t;

  assign tick = (cyc_q == CW'(TICK_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cyc_d      = tick ? '0 : cyc_q + CW'(1);
    tick_idx_d = tick_idx_q;
    spd_d      = spd_q;
    run_d      = run_q;
    drst_d     = '0;
    pend_d     = pend_q;
    all_max    = 1'b1;
    spin_exit  = 1'b0;
    sum_t      = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RAMP_UP;
          run_d      = '1;
          drst_d     = '1;
          cyc_d      = '0;
          tick_idx_d = '0;
          pend_d     = 1'b0;
          for (int unsigned k = 0; k < NUM_REELS; k++) spd_d[k] = MIN_SPEED;
        end
      end

      S_RAMP_UP: begin
        if (stop) pend_d = 1'b1;
        if (tick) begin
          // 21-bit sum so a step past 2^20-1 clamps instead of wrapping.
          for (int unsigned k = 0; k < NUM_REELS; k++) begin
            sum_t = {1'b0, spd_q[k]} + {1'b0, SPEED_STEP};
            spd_d[k] = (sum_t >= {1'b0, MAX_SPEED}) ? MAX_SPEED : sum_t[19:0];
            if (spd_d[k] != MAX_SPEED) all_max = 1'b0;
          end
          if (all_max) begin
            state_d    = S_SPIN;
            cyc_d      = '0;
            tick_idx_d = '0;
          end
        end
      end

      S_SPIN: begin
`ifdef AUTO_STOP_EN
        if (tick) tick_idx_d = tick_idx_q + 32'd1;
        spin_exit = stop || pend_q ||
                    (tick && (tick_idx_q + 32'd1 == 32'(AUTO_STOP_TICKS)));
`else
        spin_exit = stop || pend_q;
`endif
        if (spin_exit) begin
          state_d    = S_RAMP_DOWN;
          pend_d     = 1'b0;
          cyc_d      = '0;
          tick_idx_d = '0;
        end
      end

      S_RAMP_DOWN: begin
        if (tick) begin
          tick_idx_d = tick_idx_q + 32'd1;
          // Reel k starts slowing once the tick index n exceeds k*STAGGER_TICKS.
          for (int unsigned k = 0; k < NUM_REELS; k++) begin
            if (tick_idx_q + 32'd1 > 32'(k * STAGGER_TICKS)) begin
              if ({1'b0, spd_q[k]} < ({1'b0, MIN_SPEED} + {1'b0, SPEED_STEP}))
                spd_d[k] = MIN_SPEED;
              else
                spd_d[k] = spd_q[k] - SPEED_STEP;
              if (spd_d[k] == MIN_SPEED) run_d[k] = 1'b0;
            end
          end
          if (run_d == '0) state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RAMP_UP) || (state_d == S_SPIN) || (state_d == S_RAMP_DOWN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      tick_idx_q <= '0;
      for (int unsigned k = 0; k < NUM_REELS; k++) spd_q[k] <= MIN_SPEED;
      run_q      <= '0;
      drst_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      tick_idx_q <= tick_idx_d;
      for (int unsigned k = 0; k < NUM_REELS; k++) spd_q[k] <= spd_d[k];
      run_q      <= run_d;
      drst_q     <= drst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    speed = '0;
    for (int unsigned k = 0; k < NUM_REELS; k++) speed[20*k +: 20] = spd_q[k];
  end

  assign div_rst  = drst_q;
  assign reel_run = run_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule
